// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: routes M-stage data accesses to BRAM or LED/cycle/UART MMIO registers with 1-cycle read latency
module dmem_mmio_bridge #(
  parameter int DMEM_ADDR_BITS = 12,
  parameter int LED_WIDTH = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                MemWrite_EN,
  input  logic [31:0]               MemAddr,
  input  logic [31:0]               WriteData,
  output logic [31:0]               ReadData,
  output logic [3:0]                bram_we,
  output logic [DMEM_ADDR_BITS-3:0] bram_addr,
  output logic [31:0]               bram_wdata,
  input  logic [31:0]               bram_rdata,
  output logic [LED_WIDTH-1:0]      led,
  output logic                      uart_tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, data_byte;
  logic [31:0] cycle_cnt, led_wr, mmio_val, mmio_rdata_r;
  logic sel_r, overrun, busy, baud_done;
  logic mmio, wr_led, wr_cyc, wr_data, wr_stat, accept;
  logic unused_bits;
  assign unused_bits = ^{MemAddr[30:4], MemAddr[1:0]};
  assign mmio = MemAddr[31];
  assign bram_addr = MemAddr[DMEM_ADDR_BITS-1:2];
  assign bram_wdata = WriteData;
  assign bram_we = mmio ? 4'b0000 : MemWrite_EN;
  assign wr_led = mmio && MemAddr[3:2] == 2'd0;
  assign wr_cyc = mmio && MemAddr[3:2] == 2'd1 && MemWrite_EN == 4'b1111;
  assign wr_data = mmio && MemAddr[3:2] == 2'd2 && MemWrite_EN[0];
  assign wr_stat = mmio && MemAddr[3:2] == 2'd3 && MemWrite_EN[0] && WriteData[1];
  assign busy = state != IDLE;
  assign accept = wr_data && !busy;
  assign baud_done = baud == BW'(CLKS_PER_BIT - 1);
  assign uart_tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign ReadData = sel_r ? mmio_rdata_r : bram_rdata;
  always_comb begin
    led_wr = 32'(led);
    for (int i = 0; i < 4; i++)
      if (wr_led && MemWrite_EN[i]) led_wr[8*i +: 8] = WriteData[8*i +: 8];
  end
  always_comb begin
    mmio_val = MemAddr[3:2] == 2'd0 ? 32'(led) :
               MemAddr[3:2] == 2'd1 ? cycle_cnt :
               MemAddr[3:2] == 2'd2 ? {24'b0, data_byte} :
                                      {30'b0, overrun, busy};
  end
  always_comb begin
    state_n = state;
    baud_n = baud + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (accept) begin
          state_n = START;
          shift_n = WriteData[7:0];
        end
      end
      START: if (baud_done) begin
        state_n = DATA;
        baud_n = '0;
        bit_n = '0;
      end
      DATA: if (baud_done) begin
        baud_n = '0;
        shift_n = shift >> 1;
        bit_n = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = STOP;
      end
      default: if (baud_done) begin
        state_n = IDLE;
        baud_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      data_byte <= '0;
      overrun <= 1'b0;
      led <= '0;
      cycle_cnt <= '0;
      sel_r <= 1'b0;
      mmio_rdata_r <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      data_byte <= accept ? WriteData[7:0] : data_byte;
      overrun <= (wr_data && busy) || (overrun && !wr_stat);
      led <= led_wr[LED_WIDTH-1:0];
      cycle_cnt <= wr_cyc ? WriteData : cycle_cnt + 32'd1;
      sel_r <= mmio;
      mmio_rdata_r <= mmio_val;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb_dmem_mmio_bridge: directed checks of RAM decode, LED, cycle counter, UART and read latency
module tb_dmem_mmio_bridge;
  logic clk = 0;
  logic reset;
  logic [3:0] MemWrite_EN;
  logic [31:0] MemAddr, WriteData, ReadData, bram_wdata, bram_rdata;
  logic [3:0] bram_we;
  logic [9:0] bram_addr;
  logic [15:0] led;
  logic uart_tx;
  int vecs = 0;
  int errs = 0;
  dmem_mmio_bridge #(.DMEM_ADDR_BITS(12), .LED_WIDTH(16), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .MemWrite_EN(MemWrite_EN), .MemAddr(MemAddr),
    .WriteData(WriteData), .ReadData(ReadData), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .led(led), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    MemWrite_EN = we;
    MemAddr = a;
    WriteData = d;
  endtask
  task automatic test_reset();
    bram_rdata = 32'hCAFE_F00D;
    drive(4'h0, 32'h0, 32'h0);
    reset = 1;
    tick();
    tick();
    reset = 0;
    vecs++; if (led !== 16'h0) begin errs++; $display("FAIL reset_led got %h exp 0000", led); end
    vecs++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
    vecs++; if (ReadData !== 32'hCAFEF00D) begin errs++; $display("FAIL reset_rdata got %h exp cafef00d", ReadData); end
    drive(4'h0, 32'h8000_000C, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL reset_stat got %h exp 0", ReadData); end
  endtask
  task automatic test_ram();
    drive(4'hF, 32'h0000_0010, 32'h1234_ABCD);
    #1;
    vecs++; if (bram_we !== 4'hF) begin errs++; $display("FAIL ram_we got %h exp f", bram_we); end
    vecs++; if (bram_addr !== 10'd4) begin errs++; $display("FAIL ram_addr got %h exp 4", bram_addr); end
    vecs++; if (bram_wdata !== 32'h1234ABCD) begin errs++; $display("FAIL ram_wdata got %h exp 1234abcd", bram_wdata); end
    tick();
    vecs++; if (led !== 16'h0) begin errs++; $display("FAIL ram_led got %h exp 0000", led); end
    drive(4'hF, 32'h8000_0000, 32'h0000_00FF);
    #1;
    vecs++; if (bram_we !== 4'h0) begin errs++; $display("FAIL mmio_bram_we got %h exp 0", bram_we); end
  endtask
  task automatic test_led();
    drive(4'hF, 32'h8000_0000, 32'h0000_00FF);
    tick();
    vecs++; if (led !== 16'h00FF) begin errs++; $display("FAIL led_sw got %h exp 00ff", led); end
    drive(4'b0010, 32'h8000_0000, 32'h0000_A500);
    tick();
    vecs++; if (led !== 16'hA5FF) begin errs++; $display("FAIL led_sb got %h exp a5ff", led); end
    drive(4'b1000, 32'h8000_0000, 32'hFF00_0000);
    tick();
    vecs++; if (led !== 16'hA5FF) begin errs++; $display("FAIL led_upper got %h exp a5ff", led); end
    drive(4'h0, 32'h8000_0000, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h0000A5FF) begin errs++; $display("FAIL led_read got %h exp 0000a5ff", ReadData); end
  endtask
  task automatic test_cycle();
    drive(4'hF, 32'h8000_0004, 32'hFFFF_FFFE);
    tick();
    drive(4'h0, 32'h8000_0004, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'hFFFFFFFE) begin errs++; $display("FAIL cyc_load got %h exp fffffffe", ReadData); end
    tick();
    tick();
    tick();
    vecs++; if (ReadData !== 32'h1) begin errs++; $display("FAIL cyc_wrap got %h exp 1", ReadData); end
    drive(4'b0011, 32'h8000_0004, 32'h0);
    tick();
    drive(4'h0, 32'h8000_0004, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h3) begin errs++; $display("FAIL cyc_partial got %h exp 3", ReadData); end
  endtask
  task automatic test_uart_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    drive(4'b0001, 32'h8000_0008, 32'h0000_0055);
    tick();
    drive(4'h0, 32'h8000_000C, 32'h0);
    for (int k = 0; k < 40; k++) begin
      vecs++; if (uart_tx !== fr[k/4]) begin errs++; $display("FAIL uart_bit k=%0d got %b exp %b", k, uart_tx, fr[k/4]); end
      if (k == 1) begin
        vecs++; if (ReadData !== 32'h1) begin errs++; $display("FAIL uart_busy got %h exp 1", ReadData); end
      end
      tick();
    end
    vecs++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL uart_idle got %b exp 1", uart_tx); end
    tick();
    vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL uart_done got %h exp 0", ReadData); end
    drive(4'h0, 32'h8000_0008, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h55) begin errs++; $display("FAIL uart_data got %h exp 55", ReadData); end
  endtask
  task automatic test_overrun();
    logic [9:0] fr;
    fr = {1'b1, 8'h3C, 1'b0};
    drive(4'b0001, 32'h8000_0008, 32'h0000_003C);
    tick();
    drive(4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 40; k++) begin
      vecs++; if (uart_tx !== fr[k/4]) begin errs++; $display("FAIL ovr_bit k=%0d got %b exp %b", k, uart_tx, fr[k/4]); end
      if (k == 12) begin
        vecs++; if (ReadData !== 32'h3) begin errs++; $display("FAIL ovr_stat got %h exp 3", ReadData); end
      end
      if (k == 16) begin
        vecs++; if (ReadData !== 32'h1) begin errs++; $display("FAIL ovr_clear got %h exp 1", ReadData); end
      end
      drive(4'h0, 32'h0, 32'h0);
      if (k == 10) drive(4'b0001, 32'h8000_0008, 32'h0000_0099);
      if (k == 11 || k == 15) drive(4'h0, 32'h8000_000C, 32'h0);
      if (k == 14) drive(4'b0001, 32'h8000_000C, 32'h0000_0002);
      if (k == 39) drive(4'b0001, 32'h8000_0008, 32'h0000_00AA);
      tick();
    end
    drive(4'h0, 32'h8000_000C, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h2) begin errs++; $display("FAIL ovr_stop got %h exp 2", ReadData); end
    vecs++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL ovr_noframe got %b exp 1", uart_tx); end
    drive(4'h0, 32'h8000_0008, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h3C) begin errs++; $display("FAIL ovr_data got %h exp 3c", ReadData); end
  endtask
  task automatic test_reset_mid();
    drive(4'b0001, 32'h8000_0008, 32'h0000_00F0);
    tick();
    drive(4'h0, 32'h0, 32'h0);
    repeat (17) tick();
    vecs++; if (uart_tx !== 1'b0) begin errs++; $display("FAIL mid_bit3 got %b exp 0", uart_tx); end
    reset = 1;
    tick();
    reset = 0;
    vecs++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL mid_tx got %b exp 1", uart_tx); end
    drive(4'h0, 32'h8000_0004, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL mid_cyc got %h exp 0", ReadData); end
    drive(4'h0, 32'h8000_000C, 32'h0);
    tick();
    vecs++; if (ReadData !== 32'h0) begin errs++; $display("FAIL mid_stat got %h exp 0", ReadData); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] exp_prev, exp_cur;
    drive(4'hF, 32'h8000_0000, 32'h0000_1234);
    tick();
    exp_prev = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_cur = (i % 2 == 0) ? 32'h0000_1234 : 32'hCAFE_F00D;
      drive(4'h0, (i % 2 == 0) ? 32'h8000_0010 : 32'h0000_0020, 32'h0);
      #1;
      if (i > 0) begin
        vecs++; if (ReadData !== exp_prev) begin errs++; $display("FAIL b2b_hold i=%0d got %h exp %h", i, ReadData, exp_prev); end
      end
      tick();
      vecs++; if (ReadData !== exp_cur) begin errs++; $display("FAIL b2b_switch i=%0d got %h exp %h", i, ReadData, exp_cur); end
      exp_prev = exp_cur;
    end
  endtask
  initial begin
    test_reset();
    test_ram();
    test_led();
    test_cycle();
    test_uart_frame();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
Sits between the pipeline's M/W-stage data-memory interface and the synchronous data BRAM, decoding each access to either BRAM or a small MMIO register block. The MMIO block contains an LED register, a free-running cycle counter and a UART transmitter. Read data returns one cycle after the address, matching BRAM latency, so the datapath consumes it in W unchanged.

Parameters:
DMEM_ADDR_BITS, 12, byte-address width of the BRAM region (word address = DMEM_ADDR_BITS-2 bits)
LED_WIDTH, 16, width of LED output register (1..32)
CLKS_PER_BIT, 868, clock cycles per UART bit (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
MemWrite_EN  in  4  byte write enables from M stage (0000 = read/no write)
MemAddr  in  32  byte address from M stage
WriteData  in  32  lane-aligned store data from M stage
ReadData  out  32  read data, valid one cycle after MemAddr (W stage)
bram_we  out  4  BRAM byte write enables
bram_addr  out  DMEM_ADDR_BITS-2  BRAM word address
bram_wdata  out  32  BRAM write data
bram_rdata  in  32  BRAM registered read data (1-cycle latency)
led  out  LED_WIDTH  LED register
uart_tx  out  1  UART serial output, idle high

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk.
- Decode (combinational on MemAddr): MemAddr[31]==0 -> RAM; MemAddr[31]==1 -> MMIO, register chosen by MemAddr[3:2]; MemAddr[30:4] ignored (aliases).
- RAM: bram_addr = MemAddr[DMEM_ADDR_BITS-1:2]; bram_wdata = WriteData; bram_we = MemWrite_EN when RAM selected, else 0000. Purely combinational.
- MMIO map (offset from 0x8000_0000):
  0x0 LED: R/W; each byte lane i written when MemWrite_EN[i]; only bits [LED_WIDTH-1:0] stored; reads zero-extended.
  0x4 CYCLE: reads counter; counter <= counter+1 every cycle, wraps 0xFFFF_FFFF -> 0; write with MemWrite_EN==1111 loads WriteData (load wins over increment that cycle); partial writes ignored.
  0x8 UART_DATA: write with MemWrite_EN[0]==1 and busy==0 starts frame with WriteData[7:0]; same write while busy==1 is dropped and sets overrun; reads return {24'b0, last accepted byte}.
  0xC UART_STAT: read {30'b0, overrun, busy}; any write with MemWrite_EN[0]==1 and WriteData[1]==1 clears overrun; a simultaneous new overrun wins (overrun stays 1).
- Reads are side-effect free (datapath has no read strobe; every cycle is a potential read).
- Read path: at each posedge register sel_r (1 = MMIO) and mmio_rdata_r (selected MMIO value before that edge's update). ReadData = sel_r ? mmio_rdata_r : bram_rdata. Latency exactly 1 cycle for both regions.
- UART FSM states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  IDLE: uart_tx=1, busy=0; accepted write -> START, latch byte, zero baud counter.
  START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
  DATA: uart_tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 -> STOP.
  STOP: uart_tx=1 for CLKS_PER_BIT cycles -> IDLE.
  busy=1 in START/DATA/STOP; a write in the last STOP cycle is rejected (busy still 1 at that edge); frame = 10*CLKS_PER_BIT cycles.
- Reset values: led=0, counter=0, uart_tx=1, FSM=IDLE, busy=0, overrun=0, data byte=0, sel_r=0, mmio_rdata_r=0 (ReadData follows bram_rdata). Reset mid-frame aborts transmission: uart_tx=1 on the following cycle.

Test Plan:
- Reset then sw 0x1234_ABCD to 0x0000_0010 -> bram_we=1111, bram_addr=4, bram_wdata=0x1234ABCD; MMIO state unchanged, led=0.
- sb 0xA5 lane 1 (MemWrite_EN=0010, WriteData=0x0000A500) to 0x8000_0000 with led=0x00FF -> led=0xA5FF; next-cycle read of 0x8000_0000 -> ReadData=0x0000A5FF.
- sw 0xFFFF_FFFE to 0x8000_0004, then read 0x8000_0004 three cycles later -> value 0x0000_0001 (wrap verified); sh to same address -> counter unaffected.
- CLKS_PER_BIT=4: sw 0x55 to 0x8000_0008 -> uart_tx bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles; STAT reads 0x1 during frame, 0x0 after 40 cycles.
- Second write to UART_DATA mid-frame -> frame unchanged, STAT=0x3; write 0x2 to STAT -> STAT=0x1.
- Reset asserted during DATA bit 3 -> next cycle uart_tx=1, STAT=0, counter=0; alternating RAM/MMIO reads -> ReadData source switches exactly one cycle after address.
